// File: rtl/textram_ctrl.sv
// Write-port controller for the 80x25 text RAM: merges buffered CPU stores with a
// full-screen fill engine on a single registered write port, preserving program order.
module textram_ctrl #(
  parameter int DEPTH = 4,
  parameter int WORDS = 500,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_data,
  input  logic          fill_start,
  input  logic [31:0]   fill_data,
  output logic          cpu_stall,
  output logic          busy,
  output logic          fill_done,
  output logic          overflow,
  output logic          write_en,
  output logic [AW-1:0] write_address,
  output logic [31:0]   write_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [CW-1:0] ZERO_CNT  = {CW{1'b0}};
  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);
  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW-1:0] addr_mem_r [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] drain_left_r;
  logic [AW-1:0] fill_idx_r;
  logic [31:0]   pattern_r;
  logic          last_fill_r;
  logic          fill_done_r;
  logic          overflow_r;
  logic          write_en_r;
  logic [AW-1:0] write_address_r;
  logic [31:0]   write_data_r;

  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] head_addr_s;
  logic [31:0]   head_data_s;

  // FIFO handshake decode; a full FIFO rejects a store even when a pop frees a slot this cycle
  always_comb begin
    full_s      = (count_r == FULL_CNT);
    push_s      = cpu_we && !full_s;
    head_addr_s = addr_mem_r[rd_ptr_r];
    head_data_s = data_mem_r[rd_ptr_r];
    if ((state_r == IDLE || state_r == DRAIN) && (count_r != ZERO_CNT)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FIFO storage, written at the tail
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_r[wr_ptr_r] <= cpu_addr;
      data_mem_r[wr_ptr_r] <= cpu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Port arbitration FSM with registered write port and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      drain_left_r    <= ZERO_CNT;
      fill_idx_r      <= ZERO_ADDR;
      pattern_r       <= 32'h0000_0000;
      last_fill_r     <= 1'b0;
      fill_done_r     <= 1'b0;
      overflow_r      <= 1'b0;
      write_en_r      <= 1'b0;
      write_address_r <= ZERO_ADDR;
      write_data_r    <= 32'h0000_0000;
    end else begin
      write_en_r  <= 1'b0;
      last_fill_r <= 1'b0;
      fill_done_r <= last_fill_r;
      if (cpu_we && full_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            write_en_r      <= 1'b1;
            write_address_r <= head_addr_s;
            write_data_r    <= head_data_s;
          end
          if (fill_start) begin
            pattern_r <= fill_data;
            if (count_r == ZERO_CNT) begin
              // Nothing queued: word 0 goes out right away so it lands the next cycle
              write_en_r      <= 1'b1;
              write_address_r <= ZERO_ADDR;
              write_data_r    <= fill_data;
              if (WORDS == 1) begin
                last_fill_r <= 1'b1;
                state_r     <= IDLE;
              end else begin
                fill_idx_r <= ONE_ADDR;
                state_r    <= FILL;
              end
            end else if (count_r == ONE_CNT) begin
              fill_idx_r <= ZERO_ADDR;
              state_r    <= FILL;
            end else begin
              // Only entries older than the request must drain; later stores wait for the fill
              drain_left_r <= count_r - ONE_CNT;
              state_r      <= DRAIN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          write_en_r      <= 1'b1;
          write_address_r <= head_addr_s;
          write_data_r    <= head_data_s;
          if (drain_left_r == ONE_CNT) begin
            fill_idx_r <= ZERO_ADDR;
            state_r    <= FILL;
          end else begin
            drain_left_r <= drain_left_r - ONE_CNT;
            state_r      <= DRAIN;
          end
        end
        FILL: begin
          write_en_r      <= 1'b1;
          write_address_r <= fill_idx_r;
          write_data_r    <= pattern_r;
          if (fill_idx_r == LAST_ADDR) begin
            last_fill_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            fill_idx_r <= fill_idx_r + ONE_ADDR;
            state_r    <= FILL;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Busy also covers the write still sitting in the output register
  assign cpu_stall     = full_s;
  assign busy          = (state_r != IDLE) || (count_r != ZERO_CNT) || write_en_r;
  assign fill_done     = fill_done_r;
  assign overflow      = overflow_r;
  assign write_en      = write_en_r;
  assign write_address = write_address_r;
  assign write_data    = write_data_r;

endmodule

// File: doc/textram_ctrl.md
# textram_ctrl

Write-port controller for the 80x25 text-mode display RAM. Sits between the core's data-side store path and the text RAM write port, sharing that port between CPU stores (buffered in a small FIFO) and a hardware fill engine that clears or paints the whole screen at one word per cycle. CPU stores are never reordered around a fill, and the core gets a stall/status view of the shared port.

## Interface
- `DEPTH`, 4: CPU write FIFO entries; power of two, 2..16.
- `WORDS`, 500: words covered by a fill (80x25 chars, 4 chars per 32-bit word).
- `AW`, 9: text RAM word-address width.
- `clk` input 1: single clock, the VGA/text clock domain; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `cpu_we` input 1: CPU store to text RAM this cycle.
- `cpu_addr` input AW: word address of the CPU store.
- `cpu_data` input 32: store data.
- `fill_start` input 1: single-cycle request to fill words 0..WORDS-1.
- `fill_data` input 32: fill pattern, sampled with an accepted `fill_start`.
- `cpu_stall` output 1: FIFO full (count == DEPTH); combinational from count.
- `busy` output 1: state != IDLE or FIFO non-empty.
- `fill_done` output 1: one-cycle pulse after the last fill write.
- `overflow` output 1: sticky; a store arrived while full. Cleared only by reset.
- `write_en` output 1: text RAM write strobe, registered.
- `write_address` output AW: registered.
- `write_data` output 32: registered.

## Operation
- State machine: IDLE, DRAIN, FILL.
  - IDLE: if the FIFO is non-empty, pop the head to the write port.
  - IDLE + `fill_start` with FIFO empty (after this cycle's pop) -> FILL.
  - IDLE + `fill_start` with FIFO non-empty -> DRAIN. Latch `fill_data`.
  - DRAIN: pop one entry per cycle. When the FIFO becomes empty -> FILL, with no idle cycle in between.
  - FILL: issue `write_address` = 0,1,...,WORDS-1 with the latched pattern, one per cycle. After WORDS-1 -> IDLE and pulse `fill_done`.
- `fill_start` in DRAIN or FILL is ignored. No queueing and no restart.
- CPU stores enqueue in every state. During FILL the FIFO only fills; it drains after FILL ends. This keeps program order: stores before the fill request land before the fill, and stores after it land after.
- Enqueue while count == DEPTH: the store is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle. Simultaneous enqueue and pop when not full: count unchanged.
- `cpu_addr` >= WORDS is passed through unchanged; the RAM holds 2^AW words.
- FIFO pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.

## Timing
- Reset values: state IDLE, FIFO empty, `write_en` 0, `write_address` 0, `write_data` 0, `fill_done` 0, `overflow` 0, `cpu_stall` 0, `busy` 0.
- CPU store latency: store presented in cycle c (idle port, empty FIFO) -> `write_en` high in cycle c+2 (enqueue at edge end of c, pop to the output register at the end of c+1).
- Back-to-back stores drain at 1 per cycle.
- Fill with empty FIFO: `fill_start` in cycle c -> `write_en` with address 0 in cycle c+1; address WORDS-1 in cycle c+WORDS.
  - `fill_done` high in cycle c+WORDS+1.
  - `busy` low in cycle c+WORDS+1 if no stores arrived.
- `write_en` is high exactly one cycle per write and low in any cycle with nothing to issue.
- Reset in mid-fill or with a non-empty FIFO: the next cycle is in reset state, pending entries are discarded, and `write_en` is 0.

## Test plan
- Reset, then three stores (0x010/0x41414141, 0x011/0x42424242, 0x1F3/0x43434343) in consecutive cycles -> `write_en` in cycles c+2..c+4 with matching address/data in order, then `busy` low.
- `fill_start` with `fill_data`=0x20202020 and empty FIFO -> 500 consecutive writes, addresses 0..499, all 0x20202020. `fill_done` pulses once in cycle c+501. A second `fill_start` mid-fill has no effect.
- Two stores, then `fill_start` the next cycle -> both stores written first, then address 0 of the fill immediately after (DRAIN -> FILL, no gap).
- During FILL, 5 stores with DEPTH=4 -> `cpu_stall` high after the 4th. The 5th is dropped and `overflow`=1. After the fill, the 4 stores appear in order.
- `reset` asserted at fill address 250 with 2 queued stores -> `write_en`=0 from the next cycle and no further writes. `busy`=0, `overflow`=0.
